// File: rtl/lane_xform_pipe_if.sv
// Beat handshake bundle for lane_xform_pipe: upstream valid/ready/data/mode, downstream valid/ready/data.
interface lane_xform_pipe_if #(
  parameter int LANES = 4,
  parameter int WIDTH = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*WIDTH-1:0] in_data;
  logic [2*LANES-1:0]     mode;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*WIDTH-1:0] out_data;

  modport slave (
    input  in_valid, in_data, mode, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, mode, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/lane_xform_pipe.sv
// Multi-lane pass/invert/hold/zero transform feeding a DEPTH-stage elastic pipeline
// with valid/ready flow control and a registered occupancy count.
module lane_xform_pipe #(
  parameter int LANES = 4,
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  lane_xform_pipe_if.slave  bus,
  output logic [OCC_W-1:0]  occupancy
);
  localparam int DW = LANES * WIDTH;

  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] vld_nx;
  logic [DEPTH-1:0] take;
  logic [DW-1:0]    dat [DEPTH];
  logic [DW-1:0]    last_r;
  logic [DW-1:0]    xf;
  logic [OCC_W-1:0] occ_nx;
  logic             accept;

  always_comb begin
    xf = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      unique case (bus.mode[2*i +: 2])
        2'b00:   xf[i*WIDTH +: WIDTH] = bus.in_data[i*WIDTH +: WIDTH];
        2'b01:   xf[i*WIDTH +: WIDTH] = ~bus.in_data[i*WIDTH +: WIDTH];
        2'b10:   xf[i*WIDTH +: WIDTH] = last_r[i*WIDTH +: WIDTH];
        default: xf[i*WIDTH +: WIDTH] = '0;
      endcase
    end
  end

  // take[k]: stage k may be loaded on this edge (it is empty or its content moves on)
  always_comb begin
    take = '0;
    take[DEPTH-1] = !vld[DEPTH-1] || bus.out_ready;
    for (int unsigned j = 1; j < DEPTH; j++)
      take[DEPTH-1-j] = !vld[DEPTH-1-j] || take[DEPTH-j];
  end

  assign bus.in_ready  = rst_n && take[0];
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = vld[DEPTH-1];
  assign bus.out_data  = dat[DEPTH-1];

  always_comb begin
    vld_nx = vld;
    occ_nx = '0;
    if (take[0]) vld_nx[0] = bus.in_valid;
    for (int unsigned j = 1; j < DEPTH; j++)
      if (take[j]) vld_nx[j] = vld[j-1];
    for (int unsigned j = 0; j < DEPTH; j++)
      occ_nx = occ_nx + OCC_W'(vld_nx[j]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld       <= '0;
      occupancy <= '0;
      last_r    <= '0;
      for (int unsigned j = 0; j < DEPTH; j++) dat[j] <= '0;
    end else begin
      vld       <= vld_nx;
      occupancy <= occ_nx;
      if (accept) begin
        last_r <= xf;
        dat[0] <= xf;
      end
      // data only moves with a valid beat so empty stages keep their last contents
      for (int unsigned j = 1; j < DEPTH; j++)
        if (take[j] && vld[j-1]) dat[j] <= dat[j-1];
    end
  end
endmodule

// File: doc/lane_xform_pipe.md
# lane_xform_pipe

Parametrised multi-lane transform pipeline with a valid/ready handshake. It splits a packed bus into LANES lanes of WIDTH bits each and applies a per-lane mode to every lane: pass, invert, hold-last or zero. The transformed beat then moves through a DEPTH-stage elastic pipeline. The block is the next generation of the codebase's packed-array pass-through and inverter blocks: it adds configurable width, lane count and depth, a per-lane mode, and flow control.

## Interface
Parameters:
- LANES, 4, number of lanes (≥1)
- WIDTH, 8, bits per lane (≥1)
- DEPTH, 2, pipeline stages (≥1)

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst_n  input  1  reset; asynchronous, active-low
- in_valid  input  1  upstream beat valid
- in_ready  output  1  block accepts a beat this cycle
- in_data  input  LANES*WIDTH  packed beat; lane i = in_data[i*WIDTH +: WIDTH]
- mode  input  2*LANES  lane i mode = mode[2*i +: 2]; 00 pass, 01 invert, 10 hold, 11 zero
- out_valid  output  1  downstream beat valid
- out_ready  input  1  downstream accepts
- out_data  output  LANES*WIDTH  transformed beat, same lane packing as in_data
- occupancy  output  $clog2(DEPTH+1)  number of valid stages, 0..DEPTH

## Operation
- Accept: a beat is accepted when in_valid && in_ready. mode is sampled in the same cycle as in_data.
- Per-lane transform at accept:
  - pass: r = d
  - invert: r = ~d (bitwise)
  - hold: r = last_r[i]
  - zero: r = 0
- last_r[i] is a per-lane register, reset 0. It is updated with r on every accept for every lane, including hold lanes, so a hold lane keeps its value.
- Pipeline: stages s[0] (input side) through s[DEPTH-1] (output side). Each stage holds a valid bit and LANES*WIDTH data bits.
- Stage advance: s[k] advances into s[k+1] when s[k+1] is empty or s[k+1] itself advances. s[DEPTH-1] advances when out_ready is high.
- Bubbles collapse. There is no fixed spacing between beats.
- out_valid = s[DEPTH-1].valid. out_data = s[DEPTH-1].data.
- in_ready = !s[0].valid || s[0] advances. This makes a combinational path from out_ready to in_ready. That path is intended; no extra skid register is added.
- Beats are never dropped, duplicated or reordered.
- occupancy = popcount of the stage valid bits, registered and consistent with the stage state after each edge.

## Timing
- While rst_n is low, all of the following are 0: every stage valid bit, every stage data bit, last_r, out_valid, out_data, occupancy and in_ready.
- Reset assertion mid-transfer discards all in-flight beats immediately; no handshake completes.
- After rst_n deasserts, in_ready returns to 1 combinationally (pipeline empty). The first accept can happen on the first rising edge after deassertion.
- Latency: with out_ready held high, a beat accepted on edge t is visible on out_valid/out_data after edge t+DEPTH-1. With DEPTH=1 it is visible in the cycle after the accept edge.
- Throughput: 1 beat per cycle while out_ready=1 and in_valid=1.
- Full (occupancy==DEPTH, out_ready=0):
  - in_ready=0, and in_data/mode are ignored.
  - out_data is stable until accepted.
- Full with out_ready=1: the output beat leaves, all stages shift, and a new beat is accepted on the same edge. Occupancy is unchanged.
- Simultaneous accept and output with occupancy 1: occupancy stays 1.
- out_valid must not drop while out_ready=0, and out_data must not change while out_valid && !out_ready.
- Width rules: no arithmetic. Every transform preserves WIDTH bits, and lanes are independent.

## Test plan
Parameters for all scenarios: LANES=4, WIDTH=8, DEPTH=2.
1. Reset checks:
   - Reset then idle: occupancy=0, out_valid=0, out_data=0, in_ready=1.
   - Pulse rst_n low while occupancy=2: all outputs go to 0 at once.
2. Mode mix: in_data=0x80_FF_0F_A5, mode=11_10_01_00 (lanes 3..0 = zero, hold, invert, pass).
   - Beat leaves with out_data=0x00_00_F0_A5 after 2 edges, out_ready=1.
3. Hold behaviour:
   - Previous beat as in scenario 2.
   - Next beat 0x11_22_33_44, mode=10 on all lanes -> out_data=0x00_00_F0_A5.
   - Then 0x11_22_33_44, mode=00 on all lanes -> 0x11_22_33_44.
4. Backpressure:
   - out_ready=0; offer beats B0, B1, B2. Required: B0 and B1 accepted, occupancy=2, in_ready=0, out_data=B0 stable.
   - Raise out_ready: B0, B1, B2 emerge in order with no gaps.
5. Streaming: 16 beats with incrementing data, mode=01 on all lanes, out_ready=1 throughout.
   - One output per cycle, each equal to ~input.
   - occupancy stays ≤2.
6. Random stall: random in_valid and out_ready over 1000 cycles, scored against a reference model.
   - Zero mismatches.
   - No loss or reorder.
   - out_data stable whenever out_valid && !out_ready.
